gpio_bcd_tx: RTL and testbench
==============================

# gpio_bcd_tx

Transmit side of the 4-bit BCD link on the 40-pin GPIO header. A receiving board samples the nibble on its GPIO[3:0] and shows it on a seven-segment display and LEDs; this block is the sender for that link. It accepts BCD digits from the Computer_System fabric over a valid/ready handshake and buffers them in a small FIFO. It then drives each digit onto the header with a setup / strobe / hold sequence, so the far end sees a stable nibble with a qualifying strobe.

## Interface
- SETUP_CYCLES, 50: cycles the data is stable before the strobe rises (1 µs at 50 MHz); ≥1
- STROBE_CYCLES, 250: strobe high time in cycles; ≥1
- HOLD_CYCLES, 50: cycles the data is held after the strobe falls; ≥1
- FIFO_DEPTH, 4: digit buffer depth; power of 2, ≥2

Ports:
- CLOCK_50  in  1  sole clock; all state is on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_data  in  4  digit to send
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept; a transfer occurs on an edge with in_valid && in_ready
- gpio_data  out  4  nibble driven to GPIO[3:0]
- gpio_strobe  out  1  qualifier driven to GPIO[4]
- gpio_oe  out  1  output enable for the GPIO[4:0] tri-states
- busy  out  1  FSM not IDLE, or FIFO non-empty
- bad_digit  out  1  one-cycle pulse: a digit greater than 9 was rejected

## Operation
- Reset values: gpio_data=0, gpio_strobe=0, gpio_oe=0, bad_digit=0, busy=0, FIFO empty, FSM=IDLE.
- in_ready is asserted whenever the FIFO count is below FIFO_DEPTH. It is not asserted while reset is high.
- Handshake with in_data ≤ 9: the digit is written to the FIFO.
- Handshake with in_data > 9: the digit is consumed but not written. bad_digit is high for the following cycle only.
- gpio_oe is registered 1 on the first edge after reset deasserts, and stays 1.
- FSM states:
  - IDLE: strobe is 0, and gpio_data holds the last digit sent. If the FIFO is non-empty: pop, load gpio_data, go to SETUP.
  - SETUP: strobe is 0. After SETUP_CYCLES, go to STROBE.
  - STROBE: strobe is 1. After STROBE_CYCLES, go to HOLD.
  - HOLD: strobe is 0. After HOLD_CYCLES, go to SETUP with a pop and gpio_data load if the FIFO is non-empty; otherwise go to IDLE.
- A single down-counter is loaded on each state entry. Its width is $clog2 of the largest *_CYCLES parameter, plus 1.
- gpio_data changes only on a pop. It never changes while strobe is high or during HOLD.
- Push and pop on the same edge leave the count unchanged. A push is impossible while full, because in_ready is low.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-operation clears everything to reset values, so strobe drops at once. Queued digits are discarded.

## Timing
- Digit accepted at edge N into an empty FIFO with the FSM in IDLE:
  - pop and gpio_data valid at edge N+1
  - strobe rises at N+1+SETUP_CYCLES
  - strobe falls STROBE_CYCLES later
  - the FSM is in IDLE at N+1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES
- Back-to-back digit period is SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES, with no IDLE cycle between digits.
- in_ready goes high on the edge after a pop from a full FIFO.
- All outputs are registered except in_ready and busy, which are decoded from registered state.

## Structure
- Package gpio_bcd_pkg:
  - FSM state encoding (IDLE, SETUP, STROBE, HOLD)
  - BCD_MAX=9
  - nibble width 4
- Sub-module gpio_bcd_fifo: synchronous FIFO with push/pop, data, count, full/empty, and asynchronous active-high reset.
- The top level instantiates the block and drives GPIO[3:0]=gpio_oe?gpio_data:4'bz and GPIO[4]=gpio_oe?gpio_strobe:1'bz.

## Test plan
All scenarios use SETUP_CYCLES=2, STROBE_CYCLES=3, HOLD_CYCLES=2, FIFO_DEPTH=4.
- Reset held, then released: all outputs 0 and in_ready=0 during reset; gpio_oe=1 and in_ready=1 one edge after release.
- Single digit 5 accepted at edge 0:
  - gpio_data=5 at edge 1
  - strobe high from edge 3 to edge 6
  - IDLE and busy=0 at edge 8
  - gpio_data stays 5
- Digits 1..6 offered continuously from edge 0:
  - 1..5 accepted on edges 0..4; in_ready=0 after edge 4
  - digit 2 popped at edge 8; 6 accepted at edge 9
  - strobe rises at edges 3, 10, 17, 24, 31, 38 with data 1..6 in order
- Digit 12 offered, then 9: bad_digit=1 for exactly one cycle and no strobe for 12; 9 is sent with normal timing.
- Reset asserted while strobe is high with 2 digits queued: strobe=0 and gpio_data=0 immediately; after release, no strobe occurs and busy=0.
- Push of 7 on the same edge as a HOLD→SETUP pop with count=2: count stays 2, and 7 is sent after the queued digits.

Source files
------------

// File: rtl/gpio_bcd_pkg.sv
// Shared types and constants for the GPIO BCD transmit link.
package gpio_bcd_pkg;
  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/gpio_bcd_fifo.sv
// Small first-word-fall-through digit buffer; rdata shows the head entry.
module gpio_bcd_fifo
  import gpio_bcd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NIB_W-1:0] wdata,
  output logic [NIB_W-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][NIB_W-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: rtl/gpio_bcd_tx.sv
// BCD digit sender: buffers handshaked digits and drives each onto the header
// as a setup / strobe / hold sequence.
module gpio_bcd_tx
  import gpio_bcd_pkg::*;
#(
  parameter int SETUP_CYCLES  = 50,
  parameter int STROBE_CYCLES = 250,
  parameter int HOLD_CYCLES   = 50,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] gpio_data,
  output logic       gpio_strobe,
  output logic       gpio_oe,
  output logic       busy,
  output logic       bad_digit
);
  localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [NIB_W-1:0] head;
  logic [AW:0]      count;
  logic             full, empty, accept, push, pop;

  assign in_ready = !reset && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_data <= BCD_MAX);
  // Pop from IDLE, or at the end of HOLD so digits go out back to back.
  assign pop      = !empty && ((state == IDLE) || (state == HOLD && cnt == '0));
  assign busy     = (state != IDLE) || (count != '0);

  gpio_bcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (CLOCK_50),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gpio_data   <= '0;
      gpio_strobe <= 1'b0;
      gpio_oe     <= 1'b0;
      bad_digit   <= 1'b0;
    end else begin
      gpio_oe   <= 1'b1;
      bad_digit <= accept && (in_data > BCD_MAX);
      if (pop) gpio_data <= head;
      case (state)
        IDLE: if (pop) begin
          state <= SETUP;
          cnt   <= SETUP_LD;
        end
        SETUP: if (cnt == '0) begin
          state       <= STROBE;
          gpio_strobe <= 1'b1;
          cnt         <= STROBE_LD;
        end else cnt <= cnt - 1'b1;
        STROBE: if (cnt == '0) begin
          state       <= HOLD;
          gpio_strobe <= 1'b0;
          cnt         <= HOLD_LD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) begin
          if (pop) begin
            state <= SETUP;
            cnt   <= SETUP_LD;
          end else state <= IDLE;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_bcd_tx.sv
// Scoreboard bench: the driver predicts each digit's pop and strobe edge from
// the link's timing rules; a monitor checks what appears on the header.
module tb_gpio_bcd_tx;
  localparam int SU = 2, ST = 3, HO = 2, DEP = 4, PER = SU + ST + HO;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, gpio_strobe, gpio_oe, busy, bad_digit;
  logic [3:0] gpio_data;

  gpio_bcd_tx #(.SETUP_CYCLES(SU), .STROBE_CYCLES(ST), .HOLD_CYCLES(HO), .FIFO_DEPTH(DEP)) dut (
    .CLOCK_50(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gpio_data(gpio_data), .gpio_strobe(gpio_strobe), .gpio_oe(gpio_oe), .busy(busy),
    .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  typedef struct {int d; int rise;} exp_t;
  exp_t exp_q[$];
  int   inflight[$];
  bit   pop_at[int];
  int   last_pop = -1000, bad_edge = -100;
  int   n_cmp = 0, n_bad = 0;

  // Rising edges are at 5, 15, 25 ...; edge index derived from time avoids races.
  function automatic int edge_now();
    return int'(($time - 5) / 10);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, edge_now());
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    inflight.delete();
    pop_at.delete();
    last_pop = -1000;
    bad_edge = -100;
  endtask

  // One cycle of stimulus; the model decides acceptance and predicts timing.
  task automatic drive(input logic [3:0] d, input bit v, output bit acc);
    int ed, p;
    bit rdy;
    @(negedge clk);
    in_data  = d;
    in_valid = v;
    ed = edge_now();
    while (inflight.size() > 0 && inflight[0] <= ed) void'(inflight.pop_front());
    rdy = !rst && (inflight.size() < DEP);
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    ed = edge_now();
    if (acc) begin
      if (d <= 9) begin
        p = (ed + 1 > last_pop + PER) ? ed + 1 : last_pop + PER;
        last_pop = p;
        inflight.push_back(p);
        pop_at[p] = 1'b1;
        exp_q.push_back('{int'(d), p + SU});
      end else bad_edge = ed;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(4'd0, 1'b0, a);
  endtask

  task automatic send(input logic [3:0] d);
    bit a;
    int g;
    a = 1'b0;
    g = 0;
    while (!a && g < 100) begin
      drive(d, 1'b1, a);
      g++;
    end
    if (!a) chk("send_timeout", g, 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() > 0 || edge_now() < last_pop + PER) && g < 400) begin
      idle(1);
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: strobe rises must match the scoreboard in data and edge.
  logic [3:0] prev_d;
  logic       prev_s = 1'b0;
  int         hi_n = 0;
  always @(posedge clk) begin
    int   me;
    exp_t mx;
    #1;
    me = edge_now();
    if (rst) begin
      prev_s = 1'b0;
      prev_d = gpio_data;
      hi_n   = 0;
    end else begin
      if (gpio_data !== prev_d) chk("data_change_at_pop", pop_at.exists(me), 1);
      if (gpio_strobe && !prev_s) begin
        if (exp_q.size() == 0) chk("unexpected_strobe_edge", me, -1);
        else begin
          mx = exp_q.pop_front();
          chk("strobe_data", gpio_data, mx.d);
          chk("strobe_rise_edge", me, mx.rise);
        end
        hi_n = 1;
      end else if (gpio_strobe) begin
        hi_n++;
        chk("data_stable_strobe", gpio_data, prev_d);
      end else if (prev_s) chk("strobe_width", hi_n, ST);
      chk("bad_digit", bad_digit, me == bad_edge);
      chk("busy", busy, me < last_pop + PER);
      prev_s = gpio_strobe;
      prev_d = gpio_data;
    end
  end

  initial begin
    bit a;
    int g;
    // Reset held, then released
    idle(2);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_gpio_data", gpio_data, 0);
    chk("rst_strobe", gpio_strobe, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bad_digit", bad_digit, 0);
    rst = 1'b0;
    idle(1);
    #1;
    chk("oe_after_release", gpio_oe, 1);
    chk("ready_after_release", in_ready, 1);

    // Single digit
    send(4'd5);
    drain();
    chk("data_held", gpio_data, 5);

    // Continuous stream overfilling the FIFO
    for (int d = 1; d <= 6; d++) send(4'(d));
    drain();

    // Rejected digit followed by a good one
    send(4'd12);
    send(4'd9);
    drain();

    // Push coinciding with a HOLD->SETUP pop at count 2, then fill to full
    send(4'd1);
    send(4'd2);
    send(4'd3);
    idle(5);
    send(4'd7);
    send(4'd4);
    send(4'd8);
    idle(1);
    drain();

    // Randomized traffic with gaps and invalid digits
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
      send(4'($urandom_range(0, 15)));
    end
    drain();

    // Reset while strobing with two digits queued
    send(4'd3);
    send(4'd4);
    send(4'd8);
    g = 0;
    #1;
    while (!gpio_strobe && g < 20) begin
      idle(1);
      #1;
      g++;
    end
    chk("strobe_seen_before_reset", gpio_strobe, 1);
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    chk("midrst_strobe", gpio_strobe, 0);
    chk("midrst_data", gpio_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_oe", gpio_oe, 0);
    chk("midrst_ready", in_ready, 0);
    idle(2);
    rst = 1'b0;
    idle(15);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_oe", gpio_oe, 1);
    drive(4'd0, 1'b0, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
